// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> BURST -> DONE -> IDLE)
//   owner_e     : which cache engine owns the memory port
//   DEF_LINE_WORDS : default beats per line burst
//   WORD_OFF_W     : byte-offset bits within a beat (word address alignment)
package mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned WORD_OFF_W     = 2;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache and
// D-cache refill/writeback engines. Each request is a line burst of
// LINE_WORDS beats; exactly one burst is in flight at a time.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ic_req/ic_addr        I-cache line read request (held until ic_done)
//   ic_rdata/ic_rvalid    read beat returned to the I-cache
//   ic_done               one-cycle pulse when the I burst completes
//   dc_req/dc_we/dc_addr  D-cache request (we=1 writeback, we=0 refill)
//   dc_wdata              write beat, selected by beat_idx
//   dc_rdata/dc_rvalid    read beat returned to the D-cache
//   dc_done               one-cycle pulse when the D burst completes
//   beat_idx              current beat index within the active burst
//   busy_i/busy_d         owner indication during BURST and DONE
//   mem_req/mem_we        beat request / write strobe to memory
//   mem_addr/mem_wdata    beat address and write data to memory
//   mem_rdata/mem_ready   read data and beat completion from memory
module mem_arbiter
  import mem_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned LINE_WORDS = DEF_LINE_WORDS,
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              busy_i,
  output logic              busy_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned LINE_LSB = BEAT_W + WORD_OFF_W;
  localparam int unsigned LINE_W   = ADDR_W - LINE_LSB;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  // Single requester wins outright; on a tie D wins unless it was granted last.
  function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                        input owner_e last);
    owner_e win;
    if (d_req && !i_req)      win = OWN_D;
    else if (i_req && !d_req) win = OWN_I;
    else if (last == OWN_D)   win = OWN_I;
    else                      win = OWN_D;
    return win;
  endfunction

  arb_state_e        state_q,      state_d;
  owner_e            owner_q,      owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              we_q,         we_d;
  logic [LINE_W-1:0] line_q,       line_d;
  logic [BEAT_W-1:0] beat_idx_q,   beat_idx_d;

  logic [LINE_W-1:0] ic_line;
  logic [LINE_W-1:0] dc_line;
  logic              in_burst;
  logic              owner_active;
  logic              beat_read;

  // Offset bits of the request addresses select nothing: the burst always
  // starts at beat 0 of the line.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{ic_addr[LINE_LSB-1:0], dc_addr[LINE_LSB-1:0]};

  assign ic_line = ic_addr[ADDR_W-1:LINE_LSB];
  assign dc_line = dc_addr[ADDR_W-1:LINE_LSB];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    line_d       = line_q;
    beat_idx_d   = beat_idx_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (ic_req || dc_req) begin
          owner_d      = pick_owner(ic_req, dc_req, last_grant_q);
          last_grant_d = owner_d;
          we_d         = (owner_d == OWN_D) && dc_we;
          line_d       = (owner_d == OWN_D) ? dc_line : ic_line;
          beat_idx_d   = '0;
          state_d      = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (mem_ready) begin
          // LINE_WORDS is a power of two, so the increment wraps to 0 on the last beat.
          beat_idx_d = beat_idx_q + BEAT_W'(1);
          if (beat_idx_q == LAST_BEAT) state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      we_q         <= 1'b0;
      line_q       <= '0;
      beat_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      line_q       <= line_d;
      beat_idx_q   <= beat_idx_d;
    end
  end

  assign in_burst     = (state_q == ARB_BURST);
  assign owner_active = (state_q == ARB_BURST) || (state_q == ARB_DONE);
  assign beat_read    = in_burst && !we_q && mem_ready;

  assign busy_i  = owner_active && (owner_q == OWN_I);
  assign busy_d  = owner_active && (owner_q == OWN_D);
  assign ic_done = (state_q == ARB_DONE) && (owner_q == OWN_I);
  assign dc_done = (state_q == ARB_DONE) && (owner_q == OWN_D);

  assign ic_rvalid = beat_read && (owner_q == OWN_I);
  assign dc_rvalid = beat_read && (owner_q == OWN_D);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

  assign beat_idx  = beat_idx_q;
  assign mem_req   = in_burst;
  assign mem_we    = in_burst && we_q;
  assign mem_addr  = in_burst ? {line_q, beat_idx_q, {WORD_OFF_W{1'b0}}} : '0;
  assign mem_wdata = (in_burst && we_q && (owner_q == OWN_D)) ? dc_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, dc_req, dc_we, mem_ready;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic        ic_rvalid, ic_done, dc_rvalid, dc_done;
  logic        busy_i, busy_d, mem_req, mem_we;
  logic [1:0]  beat_idx;

  // Second instance with 8-beat lines
  logic        ic_req8, dc_req8, dc_we8, mem_ready8;
  logic [31:0] ic_addr8, dc_addr8, dc_wdata8, mem_rdata8;
  logic [31:0] ic_rdata8, dc_rdata8, mem_addr8, mem_wdata8;
  logic        ic_rvalid8, ic_done8, dc_rvalid8, dc_done8;
  logic        busy_i8, busy_d8, mem_req8, mem_we8;
  logic [2:0]  beat_idx8;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .beat_idx(beat_idx), .busy_i(busy_i), .busy_d(busy_d),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_arbiter #(.LINE_WORDS(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req8), .ic_addr(ic_addr8), .ic_rdata(ic_rdata8),
    .ic_rvalid(ic_rvalid8), .ic_done(ic_done8),
    .dc_req(dc_req8), .dc_we(dc_we8), .dc_addr(dc_addr8), .dc_wdata(dc_wdata8),
    .dc_rdata(dc_rdata8), .dc_rvalid(dc_rvalid8), .dc_done(dc_done8),
    .beat_idx(beat_idx8), .busy_i(busy_i8), .busy_d(busy_d8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8),
    .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8), .mem_ready(mem_ready8)
  );

  typedef struct {
    logic        ic_req;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] ic_addr;
    logic [31:0] dc_addr;
    int          period;
    logic        exp_d;
    logic        exp_we;
    logic [31:0] exp_line;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] rpat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] wpat(input int b);
    return 32'hBEEF_0000 + 32'(b * 17);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ic_rdata"}, ic_rdata, 0);
    chk({tag, " ic_rvalid"}, 32'(ic_rvalid), 0);
    chk({tag, " ic_done"}, 32'(ic_done), 0);
    chk({tag, " dc_rdata"}, dc_rdata, 0);
    chk({tag, " dc_rvalid"}, 32'(dc_rvalid), 0);
    chk({tag, " dc_done"}, 32'(dc_done), 0);
    chk({tag, " beat_idx"}, 32'(beat_idx), 0);
    chk({tag, " busy_i"}, 32'(busy_i), 0);
    chk({tag, " busy_d"}, 32'(busy_d), 0);
    chk({tag, " mem_req"}, 32'(mem_req), 0);
    chk({tag, " mem_we"}, 32'(mem_we), 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  // Called in the IDLE cycle with the request(s) already driven:
  // checks idle outputs, then lets the grant edge happen.
  task automatic grant_edge(input string tag);
    #1;
    chk({tag, " idle busy_i"}, 32'(busy_i), 0);
    chk({tag, " idle busy_d"}, 32'(busy_d), 0);
    chk({tag, " idle mem_req"}, 32'(mem_req), 0);
    @(posedge clk);
  endtask

  // Drives a whole burst on the 4-beat instance starting right after the
  // grant edge; mem_ready is high once every 'period' cycles. The owner's
  // request is dropped during DONE. With mid_evt, beat 1 changes ic_addr
  // and raises a D refill request at 0x44.
  task automatic run_burst(input string tag, input logic exp_d, input logic exp_we,
                           input logic [31:0] line, input int period, input logic mid_evt);
    logic [31:0] a;
    for (int b = 0; b < 4; b++) begin
      a = line + 32'(b * 4);
      for (int s = 0; s < period - 1; s++) begin
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk({tag, " stall mem_req"}, 32'(mem_req), 1);
        chk({tag, " stall mem_addr"}, mem_addr, a);
        chk({tag, " stall rvalid"}, 32'(ic_rvalid | dc_rvalid), 0);
        @(posedge clk);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = rpat(a);
      dc_wdata  = wpat(b);
      if (mid_evt && b == 1) begin
        ic_addr = 32'hDEAD_BEE0;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0000_0044;
      end
      #1;
      chk({tag, " mem_req"}, 32'(mem_req), 1);
      chk({tag, " mem_addr"}, mem_addr, a);
      chk({tag, " mem_we"}, 32'(mem_we), 32'(exp_we));
      chk({tag, " beat_idx"}, 32'(beat_idx), 32'(b));
      chk({tag, " busy_i"}, 32'(busy_i), 32'(!exp_d));
      chk({tag, " busy_d"}, 32'(busy_d), 32'(exp_d));
      chk({tag, " mem_wdata"}, mem_wdata, (exp_d && exp_we) ? wpat(b) : 32'h0);
      if (exp_d) begin
        chk({tag, " dc_rvalid"}, 32'(dc_rvalid), 32'(!exp_we));
        chk({tag, " ic_rvalid"}, 32'(ic_rvalid), 0);
        if (!exp_we) chk({tag, " dc_rdata"}, dc_rdata, rpat(a));
      end else begin
        chk({tag, " ic_rvalid"}, 32'(ic_rvalid), 1);
        chk({tag, " dc_rvalid"}, 32'(dc_rvalid), 0);
        chk({tag, " ic_rdata"}, ic_rdata, rpat(a));
      end
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (exp_d) dc_req = 1'b0;
    else       ic_req = 1'b0;
    #1;
    chk({tag, " ic_done"}, 32'(ic_done), 32'(!exp_d));
    chk({tag, " dc_done"}, 32'(dc_done), 32'(exp_d));
    chk({tag, " done mem_req"}, 32'(mem_req), 0);
    chk({tag, " done beat_idx"}, 32'(beat_idx), 0);
    chk({tag, " done busy"}, 32'({busy_i, busy_d}), exp_d ? 32'd1 : 32'd2);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         1, 1'b0, 1'b0, 32'h0000_0010};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0000_0064, 1, 1'b1, 1'b0, 32'h0000_0060};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0000_0064, 2, 1'b0, 1'b0, 32'h0000_0050};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0070, 32'h0000_0104, 1, 1'b1, 1'b1, 32'h0000_0100};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0104, 3, 1'b1, 1'b1, 32'h0000_0100};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_003C, 32'h0,         1, 1'b0, 1'b0, 32'h0000_0030};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_01F8, 2, 1'b1, 1'b0, 32'h0000_01F0};

    rst_n = 1'b0;
    ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0;
    dc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    ic_req8 = 1'b0; ic_addr8 = '0; dc_req8 = 1'b0; dc_we8 = 1'b0; dc_addr8 = '0;
    dc_wdata8 = '0; mem_rdata8 = '0; mem_ready8 = 1'b0;

    do_reset();
    #1;
    chk_all_zero("reset");

    // Table: single requests, ties alternating via last_grant, write/read, wait states
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      ic_req  = vecs[v].ic_req;
      dc_req  = vecs[v].dc_req;
      dc_we   = vecs[v].dc_we;
      ic_addr = vecs[v].ic_addr;
      dc_addr = vecs[v].dc_addr;
      grant_edge($sformatf("vec%0d", v));
      run_burst($sformatf("vec%0d", v), vecs[v].exp_d, vecs[v].exp_we,
                vecs[v].exp_line, vecs[v].period, 1'b0);
    end
    @(negedge clk);
    ic_req = 1'b0; dc_req = 1'b0;

    // Tie from reset: D first, pending I served right after, next tie to D
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h0000_0010;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0020;
    grant_edge("tieA");
    run_burst("tieA d", 1'b1, 1'b0, 32'h0000_0020, 1, 1'b0);
    @(negedge clk);
    grant_edge("tieA pend");
    run_burst("tieA i", 1'b0, 1'b0, 32'h0000_0010, 1, 1'b0);
    @(negedge clk);
    ic_req = 1'b1; dc_req = 1'b1;
    grant_edge("tieA again");
    run_burst("tieA d2", 1'b1, 1'b0, 32'h0000_0020, 1, 1'b0);
    @(negedge clk);
    ic_req = 1'b0; dc_req = 1'b0;

    // ic_addr change mid-burst is ignored; dc_req raised mid-burst served next
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h0000_0200;
    grant_edge("mid");
    run_burst("mid i", 1'b0, 1'b0, 32'h0000_0200, 2, 1'b1);
    @(negedge clk);
    grant_edge("mid pend");
    run_burst("mid d", 1'b1, 1'b0, 32'h0000_0040, 1, 1'b0);

    // Reset during beat 2 of a D refill
    @(negedge clk);
    ic_req = 1'b0; dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0080;
    grant_edge("rst");
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = rpat(32'h80 + 32'(b * 4));
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("rst beat2 beat_idx", 32'(beat_idx), 2);
    chk("rst beat2 busy_d", 32'(busy_d), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dc_req = 1'b0;
    #1;
    chk_all_zero("rst after");
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("rst no dc_done", 32'(dc_done), 0);
    chk("rst idle busy_d", 32'(busy_d), 0);
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 32'h0000_0010;
    grant_edge("rst new");
    run_burst("rst new i", 1'b0, 1'b0, 32'h0000_0010, 1, 1'b0);

    // LINE_WORDS=8 instance: beat_idx 0..7 and offset bits [4:2]
    @(negedge clk);
    ic_req8 = 1'b1; ic_addr8 = 32'h0000_0024;
    @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      mem_ready8 = 1'b1;
      mem_rdata8 = rpat(32'h20 + 32'(b * 4));
      #1;
      chk("lw8 beat_idx", 32'(beat_idx8), 32'(b));
      chk("lw8 mem_addr", mem_addr8, 32'h20 + 32'(b * 4));
      chk("lw8 ic_rvalid", 32'(ic_rvalid8), 1);
      chk("lw8 ic_rdata", ic_rdata8, rpat(32'h20 + 32'(b * 4)));
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready8 = 1'b0;
    ic_req8 = 1'b0;
    #1;
    chk("lw8 ic_done", 32'(ic_done8), 1);
    chk("lw8 done beat_idx", 32'(beat_idx8), 0);
    chk("lw8 done mem_req", 32'(mem_req8), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("lw8 idle busy_i", 32'(busy_i8), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
